alu_sched: RTL and testbench
============================

# alu_sched

Two-requester scheduler for the shared 8-bit ALU. It accepts operations from two independent requesters over valid/ready handshakes and arbitrates round-robin. It drives the ALU from registered operands, captures result and flags, and returns them on per-requester response handshakes. It keeps one carry flag per requester, so multi-byte ADC/SBC chains from one requester are not corrupted by the other.

## Interface
Parameters:
- `W`, default 8: datapath width. Fixed at 8 by the ALU; the parameter is for documentation only.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reqN_valid`  in  1  (N = 0, 1) operation request.
- `reqN_ready`  out  1  request accepted this cycle.
- `reqN_is_shift`  in  1  shift (1) or arithmetic/logic (0).
- `reqN_acode`  in  3  ALU operation code.
- `reqN_scode`  in  2  shift code.
- `reqN_a`, `reqN_b`  in  8  operands.
- `rspN_valid`  out  1  result available.
- `rspN_ready`  in  1  requester consumes result.
- `rspN_r`  out  8  result.
- `rspN_zero`  out  1  zero flag.
- `rspN_carry`  out  1  requester's carry register after this op.
- `rspN_err`  out  1  illegal op (acode 3'b111, non-shift).
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_carry_in`  out  1  ALU carry input.
- `alu_is_shift`  out  1  ALU shift select.
- `alu_scode`  out  2  ALU shift code.
- `alu_acode`  out  3  ALU operation code.
- `alu_r`  in  8  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `alu_carry_out`  in  1  ALU carry out.

## Operation
- FSM states IDLE, ISSUE, RESP.
- **IDLE**
  - If any `reqN_valid` is high, grant exactly one requester and assert only its `reqN_ready` (combinational).
  - Latch that requester's op, operands and id; go to ISSUE.
  - If both requesters are valid, the priority pointer decides. If only one is valid, it wins regardless of the pointer.
- **ISSUE**
  - Drive the ALU from the latched registers.
  - `alu_carry_in` is the granted requester's carry register.
  - For shifts, `alu_b` = {5'b0, b[2:0]}, i.e. the shift amount modulo 8.
  - At the end of the cycle, capture `alu_r` and `alu_zero`; go to RESP.
- **RESP**
  - Assert `rspG_valid` for the granted requester G only, and hold all rsp outputs stable.
  - When `rspG_ready` is high, go to IDLE and point priority at the other requester.
- **Carry registers** (`carry0`, `carry1`):
  - Updated from `alu_carry_out` at ISSUE capture, only for non-shift acodes 3'b000–3'b011.
  - Logic ops, shifts and illegal ops leave them unchanged.
- **Illegal op** (non-shift, acode 3'b111):
  - The ALU outputs are ignored.
  - Response is R = 8'h00, zero = 1, err = 1; carry is unchanged.
- No requests are accepted while in ISSUE or RESP; both `reqN_ready` are 0.
- When not in ISSUE, ALU control outputs hold the latched values; this is harmless because the ALU is combinational.

## Timing
- Reset values:
  - State IDLE; priority pointer 0; `carry0` = `carry1` = 0.
  - All `reqN_ready` and `rspN_valid` = 0; `rspN_r` = 0; `rspN_zero`, `rspN_carry`, `rspN_err` = 0.
  - All `alu_*` outputs = 0.
- Latency:
  - Handshake at the edge ending cycle k; ALU evaluated in cycle k+1; `rsp_valid` high in cycle k+2.
  - With `rsp_ready` tied high, there is one op per 3 cycles.
- Response backpressure holds the FSM in RESP indefinitely; the other requester waits.
- `rspN_ready` asserted while `rspN_valid` is low has no effect.
- Reset mid-operation (any state):
  - Immediate return to reset values.
  - In-flight op and response are dropped; carry registers are cleared.

## Structure
- Package `alu_sched_pkg`:
  - acode constants ADD, ADC, SUB, SBC, AND, OR, XOR, ILLEGAL.
  - scode constants SHL, SAR, ROL, ROR.
  - The FSM state enum.
- Sub-module `rr_arb2`: two-way round-robin arbiter with request inputs, grant outputs, and a pointer update strobe from RESP completion.

## Test plan
- **Carry capture:** req0 ADD A=8'h80 B=8'h80 -> rsp0 R=8'h00, zero=1, carry=1, valid in cycle k+2.
- **Carry chain isolation:**
  - Continue from the previous scenario with req1 ADD A=8'h01 B=8'h01 -> rsp1 R=8'h02, carry=0.
  - Then req0 ADC A=8'h01 B=8'h01 -> rsp0 R=8'h03, since carry0 is still 1.
- **Simultaneous requests:** after reset, both valid -> req0 granted first, then req1. Repeat with both valid -> order 0, 1, 0, 1.
- **Shift amount and illegal op:**
  - req1 shift SHL A=8'h01 B=8'h0B -> R=8'h08 (amount 3).
  - req1 acode 3'b111 -> R=8'h00, zero=1, err=1, carry1 unchanged.
- **Backpressure:** hold `rsp0_ready` low for 5 cycles with req1 valid -> `rsp0_valid` stays high with stable data; `req1_ready` stays 0 until one cycle after `rsp0_ready` rises.
- **Reset mid-op:** assert `rst` during ISSUE -> next cycle all outputs at reset values, no response issued, carries 0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// alu_sched shared types and constants.
// Opcodes, shift codes, FSM state and the latched-op bundle.
package alu_sched_pkg;

  localparam logic [2:0] ADD     = 3'b000;
  localparam logic [2:0] ADC     = 3'b001;
  localparam logic [2:0] SUB     = 3'b010;
  localparam logic [2:0] SBC     = 3'b011;
  localparam logic [2:0] AND     = 3'b100;
  localparam logic [2:0] OR      = 3'b101;
  localparam logic [2:0] XOR     = 3'b110;
  localparam logic [2:0] ILLEGAL = 3'b111;

  localparam logic [1:0] SHL = 2'b00;
  localparam logic [1:0] SAR = 2'b01;
  localparam logic [1:0] ROL = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef struct packed {
    logic       is_shift;
    logic [2:0] acode;
    logic [1:0] scode;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  // Arithmetic ops (ADD..SBC) are the only ones that own the carry.
  function automatic logic carry_op(
    input logic       is_shift,
    input logic [2:0] acode
  );
    return !is_shift && !acode[2];
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter for alu_sched.
// Pointer moves to the other side when a response completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt
);

  logic ptr_q;

  // Priority pointer: favour the requester not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (upd) begin
      ptr_q <= ~upd_id;
    end
  end

  assign gnt[0] = req[0] & (~req[1] | ~ptr_q);
  assign gnt[1] = req[1] & (~req[0] | ptr_q);

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler for the shared 8-bit ALU.
// Round-robin grant, registered operands, per-requester carry.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_is_shift,
  input  logic [2:0]   req0_acode,
  input  logic [1:0]   req0_scode,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_is_shift,
  input  logic [2:0]   req1_acode,
  input  logic [1:0]   req1_scode,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_r,
  output logic         rsp0_zero,
  output logic         rsp0_carry,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_r,
  output logic         rsp1_zero,
  output logic         rsp1_carry,
  output logic         rsp1_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_carry_in,
  output logic         alu_is_shift,
  output logic [1:0]   alu_scode,
  output logic [2:0]   alu_acode,
  input  logic [W-1:0] alu_r,
  input  logic         alu_zero,
  input  logic         alu_carry_out
);

  state_e       state_q, state_d;
  op_t          op0, op1, op_q;
  logic [1:0]   gnt;
  logic         gid_q;
  logic         carry0_q, carry1_q;
  logic [W-1:0] r_q, r_d;
  logic         zero_q, zero_d;
  logic         cout_q, err_q;
  logic         idle, accept, done;
  logic         cin, ill, upd, new_c;

  assign op0 = '{
    is_shift: req0_is_shift,
    acode:    req0_acode,
    scode:    req0_scode,
    a:        req0_a,
    b:        req0_b
  };
  assign op1 = '{
    is_shift: req1_is_shift,
    acode:    req1_acode,
    scode:    req1_scode,
    a:        req1_a,
    b:        req1_b
  };

  assign idle   = (state_q == IDLE);
  assign accept = idle & (req0_valid | req1_valid);
  assign done   = (state_q == RESP)
                & (gid_q ? rsp1_ready : rsp0_ready);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .upd    (done),
    .upd_id (gid_q),
    .gnt    (gnt)
  );

  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];

  assign cin = gid_q ? carry1_q : carry0_q;
  assign ill = !op_q.is_shift && (op_q.acode == ILLEGAL);
  assign upd = carry_op(op_q.is_shift, op_q.acode);

  // Next state: accept, evaluate for one cycle, hold until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the granted op and its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      gid_q <= 1'b0;
    end else if (accept) begin
      op_q  <= gnt[1] ? op1 : op0;
      gid_q <= gnt[1];
    end
  end

  // Result decode: illegal ops mask the ALU, arith ops take carry.
  always_comb begin
    r_d    = alu_r;
    zero_d = alu_zero;
    new_c  = cin;
    unique case (1'b1)
      ill: begin
        r_d    = '0;
        zero_d = 1'b1;
      end
      upd:     new_c = alu_carry_out;
      default: ;
    endcase
  end

  // Capture result/flags and update the owner's carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
      carry0_q <= 1'b0;
      carry1_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      r_q    <= r_d;
      zero_q <= zero_d;
      cout_q <= new_c;
      err_q  <= ill;
      if (gid_q) carry1_q <= new_c;
      else       carry0_q <= new_c;
    end
  end

  assign rsp0_valid = (state_q == RESP) & ~gid_q;
  assign rsp1_valid = (state_q == RESP) &  gid_q;
  assign rsp0_r     = r_q;
  assign rsp1_r     = r_q;
  assign rsp0_zero  = zero_q;
  assign rsp1_zero  = zero_q;
  assign rsp0_carry = cout_q;
  assign rsp1_carry = cout_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;

  assign alu_a        = op_q.a;
  assign alu_b        = op_q.is_shift
                      ? {{(W-3){1'b0}}, op_q.b[2:0]}
                      : op_q.b;
  assign alu_carry_in = cin;
  assign alu_is_shift = op_q.is_shift;
  assign alu_scode    = op_q.scode;
  assign alu_acode    = op_q.acode;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched.
// Behavioural ALU plus transaction-level reference model.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_is_shift;
  logic [2:0] req0_acode;
  logic [1:0] req0_scode;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_is_shift;
  logic [2:0] req1_acode;
  logic [1:0] req1_scode;
  logic [7:0] req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp0_zero, rsp0_carry, rsp0_err;
  logic [7:0] rsp0_r;
  logic       rsp1_valid, rsp1_ready, rsp1_zero, rsp1_carry, rsp1_err;
  logic [7:0] rsp1_r;
  logic [7:0] alu_a, alu_b, alu_r;
  logic       alu_carry_in, alu_is_shift, alu_zero, alu_carry_out;
  logic [1:0] alu_scode;
  logic [2:0] alu_acode;

  alu_sched #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_is_shift(req0_is_shift), .req0_acode(req0_acode),
    .req0_scode(req0_scode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_is_shift(req1_is_shift), .req1_acode(req1_acode),
    .req1_scode(req1_scode), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_r(rsp0_r), .rsp0_zero(rsp0_zero),
    .rsp0_carry(rsp0_carry), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_r(rsp1_r), .rsp1_zero(rsp1_zero),
    .rsp1_carry(rsp1_carry), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_is_shift(alu_is_shift), .alu_scode(alu_scode),
    .alu_acode(alu_acode), .alu_r(alu_r), .alu_zero(alu_zero),
    .alu_carry_out(alu_carry_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; non-arith ops drive carry_out=1 on purpose.
  logic [8:0]  s9;
  logic [15:0] rot;
  always_comb begin
    s9 = '0;
    rot = '0;
    alu_r = '0;
    alu_carry_out = 1'b1;
    if (alu_is_shift) begin
      case (alu_scode)
        SHL: alu_r = alu_a << alu_b;
        SAR: alu_r = $signed(alu_a) >>> alu_b;
        ROL: begin
          rot = {alu_a, alu_a} << alu_b[2:0];
          alu_r = rot[15:8];
        end
        default: begin
          rot = {alu_a, alu_a} >> alu_b[2:0];
          alu_r = rot[7:0];
        end
      endcase
    end else begin
      case (alu_acode)
        ADD: s9 = {1'b0, alu_a} + {1'b0, alu_b};
        ADC: s9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'h0, alu_carry_in};
        SUB: s9 = {1'b0, alu_a} - {1'b0, alu_b};
        SBC: s9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'h0, alu_carry_in};
        AND: s9 = {1'b1, alu_a & alu_b};
        OR:  s9 = {1'b1, alu_a | alu_b};
        XOR: s9 = {1'b1, alu_a ^ alu_b};
        default: s9 = 9'h1A5;
      endcase
      alu_r = s9[7:0];
      alu_carry_out = s9[8];
    end
    alu_zero = (alu_r == 8'h00);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference model state
  bit         m_busy;
  int         m_cnt, m_id, m_prio;
  bit         m_carry[2];
  logic [7:0] e_r, e_a, e_b;
  logic       e_z, e_c, e_e, e_cin, e_sh;
  logic [2:0] e_ac;
  logic [1:0] e_sc;
  int         grant_log[$];
  int         rsp_done = 0;
  logic [7:0] last_r;
  logic       last_z, last_c, last_e;

  // Expected result straight from the operation definitions.
  task automatic model_ref(
    input  logic       sh,
    input  logic [2:0] ac,
    input  logic [1:0] sc,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] r,
    output logic       z,
    output logic       c,
    output logic       e
  );
    int s, amt, sv;
    s = 0;
    e = 1'b0;
    c = cin;
    if (sh) begin
      amt = int'(b) % 8;
      case (sc)
        SHL: s = int'(a) << amt;
        SAR: begin
          sv = int'(a);
          if (a >= 8'd128) sv = sv - 256;
          s = sv >>> amt;
        end
        ROL: s = (int'(a) << amt) | (int'(a) >> (8 - amt));
        default: s = (int'(a) >> amt) | (int'(a) << (8 - amt));
      endcase
    end else begin
      case (ac)
        ADD: begin s = int'(a) + int'(b); c = s[8]; end
        ADC: begin s = int'(a) + int'(b) + int'(cin); c = s[8]; end
        SUB: begin s = int'(a) - int'(b); c = s[8]; end
        SBC: begin s = int'(a) - int'(b) - int'(cin); c = s[8]; end
        AND: s = int'(a & b);
        OR:  s = int'(a | b);
        XOR: s = int'(a ^ b);
        default: begin s = 0; e = 1'b1; end
      endcase
    end
    r = s[7:0];
    z = (r == 8'h00);
  endtask

  // One cycle: check outputs against the model, then advance.
  task automatic step();
    int win;
    logic sh;
    logic [2:0] ac;
    logic [1:0] sc;
    logic [7:0] a, b;
    logic [10:0] obs;
    #1;
    if (m_busy) begin
      m_cnt++;
      chk("ready_busy", 32'({req1_ready, req0_ready}), 0);
      if (m_cnt == 1) begin
        chk("issue_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        chk("alu_ab", 32'({alu_a, alu_b}), 32'({e_a, e_b}));
        chk("alu_ctl",
            32'({alu_is_shift, alu_acode, alu_scode, alu_carry_in}),
            32'({e_sh, e_ac, e_sc, e_cin}));
      end else begin
        chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}),
            (m_id == 1) ? 2 : 1);
        obs = (m_id == 1)
            ? {rsp1_r, rsp1_zero, rsp1_carry, rsp1_err}
            : {rsp0_r, rsp0_zero, rsp0_carry, rsp0_err};
        chk("rsp_data", 32'(obs), 32'({e_r, e_z, e_c, e_e}));
        if ((m_id == 1) ? rsp1_ready : rsp0_ready) begin
          last_r = obs[10:3];
          last_z = obs[2];
          last_c = obs[1];
          last_e = obs[0];
          m_busy = 1'b0;
          m_prio = 1 - m_id;
          rsp_done++;
        end
      end
    end else begin
      win = -1;
      if (req0_valid && req1_valid) win = m_prio;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
      chk("ready0", 32'(req0_ready), 32'(win == 0));
      chk("ready1", 32'(req1_ready), 32'(win == 1));
      chk("idle_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
      if (win >= 0) begin
        if (win == 0)
          {sh, ac, sc, a, b} = {req0_is_shift, req0_acode,
                                req0_scode, req0_a, req0_b};
        else
          {sh, ac, sc, a, b} = {req1_is_shift, req1_acode,
                                req1_scode, req1_a, req1_b};
        e_sh = sh;
        e_ac = ac;
        e_sc = sc;
        e_a = a;
        e_b = sh ? (b & 8'h07) : b;
        e_cin = m_carry[win];
        model_ref(sh, ac, sc, a, b, m_carry[win], e_r, e_z, e_c, e_e);
        m_carry[win] = e_c;
        m_id = win;
        m_busy = 1'b1;
        m_cnt = 0;
        grant_log.push_back(win);
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'({req1_ready, req0_ready}), 0);
    chk({tag, "_rsp0"}, 32'({rsp0_valid, rsp0_r, rsp0_zero,
                            rsp0_carry, rsp0_err}), 0);
    chk({tag, "_rsp1"}, 32'({rsp1_valid, rsp1_r, rsp1_zero,
                            rsp1_carry, rsp1_err}), 0);
    chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_carry_in, alu_is_shift,
                           alu_scode, alu_acode}), 0);
  endtask

  // Assert reset at a falling edge, check, release at the next one.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk_reset(tag);
    m_busy = 1'b0;
    m_prio = 0;
    m_carry[0] = 1'b0;
    m_carry[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 30; i++) begin
      if (rsp_done >= target) break;
      step();
    end
    chk("rsp_timeout", 32'(rsp_done >= target), 1);
  endtask

  task automatic set_req(input int id, input logic sh,
                         input logic [2:0] ac, input logic [1:0] sc,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      {req0_valid, req0_is_shift, req0_acode} = {1'b1, sh, ac};
      {req0_scode, req0_a, req0_b} = {sc, a, b};
    end else begin
      {req1_valid, req1_is_shift, req1_acode} = {1'b1, sh, ac};
      {req1_scode, req1_a, req1_b} = {sc, a, b};
    end
  endtask

  task automatic do_op(input int id, input logic sh,
                       input logic [2:0] ac, input logic [1:0] sc,
                       input logic [7:0] a, input logic [7:0] b);
    int g0, d0;
    g0 = grant_log.size();
    d0 = rsp_done;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(id, sh, ac, sc, a, b);
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant_log.size() > g0) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done(d0 + 1);
  endtask

  initial begin
    int g0, d0;
    rst = 1'b1;
    {req0_valid, req0_is_shift, req0_acode, req0_scode} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
    {req1_valid, req1_is_shift, req1_acode, req1_scode} = '0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    @(negedge clk);
    do_reset("reset");

    do_op(0, 1'b0, ADD, SHL, 8'h80, 8'h80);
    chk("cap_rsp", 32'({last_r, last_z, last_c, last_e}),
        32'({8'h00, 1'b1, 1'b1, 1'b0}));
    do_op(1, 1'b0, ADD, SHL, 8'h01, 8'h01);
    chk("iso_r1", 32'({last_r, last_c}), 32'({8'h02, 1'b0}));
    do_op(0, 1'b0, ADC, SHL, 8'h01, 8'h01);
    chk("iso_adc0", 32'(last_r), 32'h03);
    do_op(1, 1'b1, ADD, SHL, 8'h01, 8'h0B);
    chk("shl_mod8", 32'(last_r), 32'h08);
    do_op(1, 1'b0, ILLEGAL, SHL, 8'h5A, 8'h33);
    chk("illegal", 32'({last_r, last_z, last_c, last_e}),
        32'({8'h00, 1'b1, 1'b0, 1'b1}));

    do_reset("reset2");
    g0 = grant_log.size();
    d0 = rsp_done;
    set_req(0, 1'b0, ADD, SHL, 8'h01, 8'h02);
    set_req(1, 1'b0, SUB, SHL, 8'h09, 8'h03);
    for (int i = 0; i < 40; i++) begin
      if (grant_log.size() >= g0 + 4) break;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done(d0 + 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", 32'(grant_log[g0 + i]), 32'(i % 2));

    g0 = grant_log.size();
    d0 = rsp_done;
    set_req(0, 1'b0, XOR, SHL, 8'hF0, 8'h3C);
    rsp0_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant_log.size() > g0) break;
    end
    req0_valid = 1'b0;
    set_req(1, 1'b0, ADD, SHL, 8'h05, 8'h06);
    step();
    repeat (5) step();
    chk("bp_hold", 32'({rsp0_valid, req1_ready, rsp0_r}),
        32'({1'b1, 1'b0, 8'hCC}));
    rsp0_ready = 1'b1;
    step();
    step();
    req1_valid = 1'b0;
    chk("bp_next", 32'(grant_log[grant_log.size() - 1]), 1);
    wait_done(d0 + 2);

    do_op(0, 1'b0, ADD, SHL, 8'hFF, 8'h01);
    do_op(1, 1'b0, ADD, SHL, 8'hFF, 8'h01);
    g0 = grant_log.size();
    set_req(0, 1'b0, ADC, SHL, 8'h01, 8'h01);
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant_log.size() > g0) break;
    end
    do_reset("rst_mid");
    d0 = rsp_done;
    repeat (3) step();
    chk("rst_dropped", 32'(rsp_done), 32'(d0));
    do_op(0, 1'b0, ADC, SHL, 8'h01, 8'h01);
    chk("rst_carry0", 32'({last_r, last_c}), 32'({8'h02, 1'b0}));
    do_op(1, 1'b0, ADC, SHL, 8'h01, 8'h01);
    chk("rst_carry1", 32'({last_r, last_c}), 32'({8'h02, 1'b0}));

    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(2) != 0);
      req0_is_shift = 1'($urandom);
      req0_acode = 3'($urandom);
      req0_scode = 2'($urandom);
      req0_a = 8'($urandom);
      req0_b = 8'($urandom);
      req1_valid = ($urandom_range(2) != 0);
      req1_is_shift = 1'($urandom);
      req1_acode = 3'($urandom);
      req1_scode = 2'($urandom);
      req1_a = 8'($urandom);
      req1_b = 8'($urandom);
      rsp0_ready = ($urandom_range(3) != 0);
      rsp1_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
